matmul_4x4_sequencer: RTL and testbench
=======================================

// Module: matmul_4x4_sequencer
// PURPOSE
//  Control sequencer for the 4x4 matrix multiplier: on a host start command it walks
//  i,j,k over the operand RAM, computes C = A x B with one multiply-accumulate unit,
//  writes C back to the same RAM and pulses EnableListo into the ready-flag register (0x184).
//  Owns the single RAM port while busy; passes host bus traffic through to the RAM when idle.
// PARAMETERS
//  DATA_W     16       element width, signed two's complement (A, B, C)
//  A_BASE     9'h100   A[i][k] at A_BASE + 4*i + k
//  B_BASE     9'h110   B[k][j] at B_BASE + 4*k + j
//  C_BASE     9'h120   C[i][j] at C_BASE + 4*i + j
//  CTRL_ADDR  9'h180   start register (write DataIn[0]=1 to start)
// PORTS
//  CLK          in   1       single clock, all state on posedge
//  ResetMaster  in   1       asynchronous, active-high reset
//  Write        in   1       host write strobe
//  Address      in   9       host address
//  DataIn       in   DATA_W  host write data
//  MemAddr      out  9       RAM address
//  MemWe        out  1       RAM write enable
//  MemWData     out  DATA_W  RAM write data
//  MemRData     in   DATA_W  RAM read data, synchronous read, 1-cycle latency
//  Busy         out  1       high from start acceptance until DONE exit
//  EnableListo  out  1       1-cycle done pulse to ready-flag register
// BEHAVIOUR
//  Reset: state IDLE; i=j=k=0; acc=0; a_reg=0; Busy=0; EnableListo=0. Async, any state.
//  Reset mid-run aborts; partial C already written stays in RAM, no EnableListo.
//  IDLE: Busy=0; MemAddr=Address, MemWData=DataIn, MemWe=Write & (Address!=CTRL_ADDR)
//   (combinational pass-through). Write & Address==CTRL_ADDR & DataIn[0] -> RD_A next edge.
//   Start write with DataIn[0]=0: no effect.
//  RD_A: MemAddr=A_BASE+4i+k, MemWe=0 -> RD_B.
//  RD_B: MemAddr=B_BASE+4k+j; a_reg<=MemRData -> MAC.
//  MAC:  acc <= (k==0 ? 0 : acc) + a_reg*MemRData (signed, acc width 2*DATA_W+2);
//        k==3 -> WR_C (k<=0) else k<=k+1 -> RD_A.
//  WR_C: MemAddr=C_BASE+4i+j, MemWe=1, MemWData=acc[DATA_W-1:0] (truncate, no saturation);
//        advance j; j wraps 3->0 with i+1; after (i,j)=(3,3) -> DONE, else -> RD_A.
//  DONE: EnableListo=1 for exactly this cycle; Busy=1; -> IDLE.
//  Busy=1 in RD_A..DONE. Host Write/start while Busy: ignored, not queued, RAM not driven
//   by host. Host reads while Busy return sequencer-selected data (undefined to host).
//  Latency: start-write edge E0; RD_A in cycle 1; 16 elements x 13 cycles (4x3 + WR_C);
//   DONE in cycle 209 (EnableListo high), IDLE from cycle 210, next start accepted then.
//  Element order: C00,C01,C02,C03,C10,...,C33; C write of (i,j) precedes reads of next.
//  In-place aliasing (C region overlapping A/B) not supported; bases fixed by parameters.
// STRUCTURE
//  Package matmul_pkg: state enum {IDLE,RD_A,RD_B,MAC,WR_C,DONE}; address constants
//   A_BASE/B_BASE/C_BASE/CTRL_ADDR/LISTO_ADDR (9'h184); DATA_W default.
//  Sub-module mac_unit: signed DATA_W x DATA_W multiply, accumulator with clear-on-first,
//   async reset; sequencer holds FSM, i/j/k counters, address gen and bus mux.
// TESTING
//  1 A=identity, B=1..16 row-major, start -> C region equals B; EnableListo single pulse
//    exactly 209 cycles after start edge; Busy high cycles 1..209.
//  2 A all 2, B all -3 -> every C = -24 (16'hFFE8); signed path checked.
//  3 A all 16'h7FFF, B all 16'h7FFF -> C = low 16 bits of 4*0x3FFF0001 = 16'h0004 (truncation).
//  4 Host writes B_BASE=9'h110 data 16'h1234 while Busy, plus second start -> RAM word
//    unchanged by host, only one EnableListo, no restart.
//  5 Assert ResetMaster at cycle 100 of a run -> Busy, EnableListo 0 same cycle (async);
//    IDLE; new start afterwards completes with correct C.
//  6 Start write with DataIn=0 and idle host RAM write/read at 9'h105 -> no Busy;
//    MemWe follows Write; RAM readback matches written data.

Source files
------------

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types, address map and helpers for the 4x4 matrix multiplier
package matmul_pkg;

    localparam int DATA_W = 16;

    localparam logic [8:0] A_BASE     = 9'h100;
    localparam logic [8:0] B_BASE     = 9'h110;
    localparam logic [8:0] C_BASE     = 9'h120;
    localparam logic [8:0] CTRL_ADDR  = 9'h180;
    localparam logic [8:0] LISTO_ADDR = 9'h184;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        MAC,
        WR_C,
        DONE
    } state_t;

    // Row-major element address inside a 4x4 block starting at base.
    function automatic logic [8:0] elem_addr(logic [8:0] base, logic [1:0] row, logic [1:0] col);
        return base + {5'd0, row, col};
    endfunction

endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - signed multiply-accumulate with clear-on-first-term
module mac_unit #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o
);

    localparam int ACC_W = 2 * DATA_W + 2;

    logic signed [2*DATA_W-1:0] prod;
    logic        [ACC_W-1:0]    prod_ext;
    logic        [ACC_W-1:0]    acc_d;
    logic        [ACC_W-1:0]    acc_q;

    always_comb begin
        prod     = $signed(a_i) * $signed(b_i);
        prod_ext = {{2{prod[2*DATA_W-1]}}, prod};
        // First term of a dot product overwrites instead of adding, so no separate clear cycle.
        acc_d    = clear_i ? prod_ext : acc_q + prod_ext;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    assign result_o = acc_q[DATA_W-1:0];

endmodule

// File: rtl/matmul_4x4_sequencer.sv
// rtl/matmul_4x4_sequencer.sv - walks i,j,k over the operand RAM computing C = A x B
module matmul_4x4_sequencer
    import matmul_pkg::*;
#(
    parameter int         DATA_W    = matmul_pkg::DATA_W,
    parameter logic [8:0] A_BASE    = matmul_pkg::A_BASE,
    parameter logic [8:0] B_BASE    = matmul_pkg::B_BASE,
    parameter logic [8:0] C_BASE    = matmul_pkg::C_BASE,
    parameter logic [8:0] CTRL_ADDR = matmul_pkg::CTRL_ADDR
) (
    input  logic              CLK,
    input  logic              ResetMaster,
    input  logic              Write,
    input  logic [8:0]        Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic [8:0]        MemAddr,
    output logic              MemWe,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    output logic              Busy,
    output logic              EnableListo
);

    state_t            state_q, state_d;
    logic [1:0]        i_q, i_d;
    logic [1:0]        j_q, j_d;
    logic [1:0]        k_q, k_d;
    logic [DATA_W-1:0] a_reg_q, a_reg_d;
    logic              mac_en;
    logic [DATA_W-1:0] acc_lo;

    mac_unit #(.DATA_W(DATA_W)) u_mac (
        .clk_i    (CLK),
        .rst_i    (ResetMaster),
        .en_i     (mac_en),
        .clear_i  (k_q == 2'd0),
        .a_i      (a_reg_q),
        .b_i      (MemRData),
        .result_o (acc_lo)
    );

    always_ff @(posedge CLK or posedge ResetMaster) begin
        if (ResetMaster) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_reg_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            a_reg_q <= a_reg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        a_reg_d     = a_reg_q;
        mac_en      = 1'b0;
        MemAddr     = Address;
        MemWData    = acc_lo;
        MemWe       = 1'b0;
        Busy        = 1'b1;
        EnableListo = 1'b0;

        case (state_q)
            IDLE: begin
                Busy     = 1'b0;
                MemWData = DataIn;
                MemWe    = Write && (Address != CTRL_ADDR);
                if (Write && (Address == CTRL_ADDR) && DataIn[0]) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = RD_A;
                end
            end
            RD_A: begin
                MemAddr = elem_addr(A_BASE, i_q, k_q);
                state_d = RD_B;
            end
            RD_B: begin
                // A[i][k] arrives now, one cycle after its address was presented.
                MemAddr = elem_addr(B_BASE, k_q, j_q);
                a_reg_d = MemRData;
                state_d = MAC;
            end
            MAC: begin
                MemAddr = elem_addr(B_BASE, k_q, j_q);
                mac_en  = 1'b1;
                k_d     = k_q + 2'd1;
                state_d = (k_q == 2'd3) ? WR_C : RD_A;
            end
            WR_C: begin
                MemAddr = elem_addr(C_BASE, i_q, j_q);
                MemWe   = 1'b1;
                j_d     = j_q + 2'd1;
                if (j_q == 2'd3) begin
                    i_d = i_q + 2'd1;
                end
                state_d = (i_q == 2'd3 && j_q == 2'd3) ? DONE : RD_A;
            end
            DONE: begin
                EnableListo = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_matmul_4x4_sequencer.sv
// tb/tb_matmul_4x4_sequencer.sv - randomized self-checking bench with RAM and matrix reference model
module tb_matmul_4x4_sequencer;

    localparam logic [8:0] A_BASE    = 9'h100;
    localparam logic [8:0] B_BASE    = 9'h110;
    localparam logic [8:0] C_BASE    = 9'h120;
    localparam logic [8:0] CTRL_ADDR = 9'h180;
    localparam int         DONE_CYC  = 209;

    logic        CLK = 1'b0;
    logic        ResetMaster = 1'b1;
    logic        Write = 1'b0;
    logic [8:0]  Address = '0;
    logic [15:0] DataIn = '0;
    logic [8:0]  MemAddr;
    logic        MemWe;
    logic [15:0] MemWData;
    logic [15:0] MemRData = '0;
    logic        Busy;
    logic        EnableListo;

    int checks = 0;
    int errors = 0;

    logic [15:0] ram [0:511];
    logic [15:0] am [16];
    logic [15:0] bm [16];
    logic [8:0]  wr_log [$];

    matmul_4x4_sequencer dut (
        .CLK         (CLK),
        .ResetMaster (ResetMaster),
        .Write       (Write),
        .Address     (Address),
        .DataIn      (DataIn),
        .MemAddr     (MemAddr),
        .MemWe       (MemWe),
        .MemWData    (MemWData),
        .MemRData    (MemRData),
        .Busy        (Busy),
        .EnableListo (EnableListo)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (MemWe) ram[MemAddr] <= MemWData;
        MemRData <= ram[MemAddr];
        if (Busy && MemWe) wr_log.push_back(MemAddr);
    end

    function automatic logic [15:0] ref_c(int i, int j);
        logic signed [63:0] s;
        s = 0;
        for (int k = 0; k < 4; k++)
            s = s + 64'($signed(am[4*i+k])) * 64'($signed(bm[4*k+j]));
        return s[15:0];
    endfunction

    task automatic host_write(input logic [8:0] addr, input logic [15:0] data);
        @(negedge CLK);
        Write = 1'b1; Address = addr; DataIn = data;
        @(posedge CLK);
        #1 Write = 1'b0;
    endtask

    task automatic load_mats();
        for (int n = 0; n < 16; n++) host_write(A_BASE + 9'(n), am[n]);
        for (int n = 0; n < 16; n++) host_write(B_BASE + 9'(n), bm[n]);
    endtask

    // Starts a job and observes 220 cycles; optionally injects a host write and a second start.
    task automatic run_job(input int host_wr_cyc, input int restart_cyc,
                           output int pulse_cnt, output int pulse_cyc, output int busy_bad);
        @(negedge CLK);
        Write = 1'b1; Address = CTRL_ADDR; DataIn = 16'h0001;
        @(posedge CLK);
        pulse_cnt = 0; pulse_cyc = -1; busy_bad = 0;
        for (int n = 1; n <= 220; n++) begin
            @(negedge CLK);
            if (n == 1) begin Write = 1'b0; DataIn = '0; end
            if (n == host_wr_cyc) begin Write = 1'b1; Address = B_BASE; DataIn = 16'h1234; end
            if (n == restart_cyc) begin Write = 1'b1; Address = CTRL_ADDR; DataIn = 16'h0001; end
            if ((n == host_wr_cyc + 1) || (n == restart_cyc + 1)) Write = 1'b0;
            if (EnableListo) begin pulse_cnt++; pulse_cyc = n; end
            if (Busy !== (n <= DONE_CYC)) busy_bad++;
        end
    endtask

    task automatic check_c(input string tag);
        for (int e = 0; e < 16; e++) begin
            checks++;
            if (ram[C_BASE + 9'(e)] !== ref_c(e / 4, e % 4)) begin
                errors++;
                $display("FAIL %s C[%0d][%0d]: got %h expected %h", tag, e / 4, e % 4,
                         ram[C_BASE + 9'(e)], ref_c(e / 4, e % 4));
            end
        end
    endtask

    task automatic check_timing(input string tag, input int pc, input int pcyc, input int bb);
        checks++;
        if (pc !== 1) begin errors++; $display("FAIL %s pulse count: got %0d expected 1", tag, pc); end
        checks++;
        if (pcyc !== DONE_CYC) begin errors++; $display("FAIL %s pulse cycle: got %0d expected %0d", tag, pcyc, DONE_CYC); end
        checks++;
        if (bb !== 0) begin errors++; $display("FAIL %s busy window: %0d bad cycles expected 0", tag, bb); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        checks++;
        if (Busy !== 1'b0 || EnableListo !== 1'b0 || MemWe !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: busy=%b listo=%b we=%b expected 0 0 0", Busy, EnableListo, MemWe);
        end
        ResetMaster = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_identity();
        int pc, pcyc, bb;
        for (int n = 0; n < 16; n++) begin
            am[n] = (n / 4 == n % 4) ? 16'd1 : 16'd0;
            bm[n] = 16'(n + 1);
        end
        load_mats();
        wr_log.delete();
        run_job(0, 0, pc, pcyc, bb);
        check_timing("identity", pc, pcyc, bb);
        check_c("identity");
        checks++;
        if (wr_log.size() !== 16) begin
            errors++; $display("FAIL identity write count: got %0d expected 16", wr_log.size());
        end else begin
            for (int e = 0; e < 16; e++) begin
                checks++;
                if (wr_log[e] !== C_BASE + 9'(e)) begin
                    errors++; $display("FAIL identity order %0d: got %h expected %h", e, wr_log[e], C_BASE + 9'(e));
                end
            end
        end
    endtask

    task automatic test_signed();
        int pc, pcyc, bb;
        for (int n = 0; n < 16; n++) begin am[n] = 16'd2; bm[n] = 16'hFFFD; end
        load_mats();
        run_job(0, 0, pc, pcyc, bb);
        check_timing("signed", pc, pcyc, bb);
        checks++;
        if (ram[C_BASE + 9'd5] !== 16'hFFE8) begin
            errors++; $display("FAIL signed C11 const: got %h expected ffe8", ram[C_BASE + 9'd5]);
        end
        check_c("signed");
    endtask

    task automatic test_truncate();
        int pc, pcyc, bb;
        for (int n = 0; n < 16; n++) begin am[n] = 16'h7FFF; bm[n] = 16'h7FFF; end
        load_mats();
        run_job(0, 0, pc, pcyc, bb);
        check_timing("truncate", pc, pcyc, bb);
        checks++;
        if (ram[C_BASE + 9'd15] !== 16'h0004) begin
            errors++; $display("FAIL truncate C33 const: got %h expected 0004", ram[C_BASE + 9'd15]);
        end
        check_c("truncate");
    endtask

    task automatic test_random();
        int pc, pcyc, bb;
        for (int r = 0; r < 2; r++) begin
            for (int n = 0; n < 16; n++) begin am[n] = 16'($urandom); bm[n] = 16'($urandom); end
            load_mats();
            run_job(0, 0, pc, pcyc, bb);
            check_timing("random", pc, pcyc, bb);
            check_c("random");
        end
    endtask

    task automatic test_busy_ignore();
        int pc, pcyc, bb;
        for (int n = 0; n < 16; n++) begin am[n] = 16'($urandom_range(0, 200)); bm[n] = 16'($urandom); end
        load_mats();
        run_job(5, 40, pc, pcyc, bb);
        check_timing("busy_ignore", pc, pcyc, bb);
        checks++;
        if (ram[B_BASE] !== bm[0]) begin
            errors++; $display("FAIL busy_ignore B00 word: got %h expected %h", ram[B_BASE], bm[0]);
        end
        check_c("busy_ignore");
    endtask

    task automatic test_abort();
        int pc, pcyc, bb;
        for (int n = 0; n < 16; n++) begin am[n] = 16'($urandom); bm[n] = 16'($urandom); end
        load_mats();
        for (int n = 0; n < 16; n++) host_write(C_BASE + 9'(n), 16'hDEAD);
        @(negedge CLK);
        Write = 1'b1; Address = CTRL_ADDR; DataIn = 16'h0001;
        @(posedge CLK);
        for (int n = 1; n <= 100; n++) begin
            @(negedge CLK);
            if (n == 1) begin Write = 1'b0; DataIn = '0; end
        end
        ResetMaster = 1'b1;
        #1;
        checks++;
        if (Busy !== 1'b0 || EnableListo !== 1'b0) begin
            errors++; $display("FAIL abort async: busy=%b listo=%b expected 0 0", Busy, EnableListo);
        end
        @(negedge CLK);
        ResetMaster = 1'b0;
        pc = 0; bb = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (Busy !== 1'b0) bb++;
            if (EnableListo !== 1'b0) pc++;
        end
        checks++;
        if (bb !== 0 || pc !== 0) begin
            errors++; $display("FAIL abort idle: busy cycles %0d listo cycles %0d expected 0 0", bb, pc);
        end
        checks++;
        if (ram[C_BASE + 9'd6] !== ref_c(1, 2)) begin
            errors++; $display("FAIL abort partial C12: got %h expected %h", ram[C_BASE + 9'd6], ref_c(1, 2));
        end
        checks++;
        if (ram[C_BASE + 9'd7] !== 16'hDEAD) begin
            errors++; $display("FAIL abort unwritten C13: got %h expected dead", ram[C_BASE + 9'd7]);
        end
        run_job(0, 0, pc, pcyc, bb);
        check_timing("abort_rerun", pc, pcyc, bb);
        check_c("abort_rerun");
    endtask

    task automatic test_idle_passthrough();
        logic [15:0] d;
        int bb;
        d = 16'($urandom);
        @(negedge CLK);
        Write = 1'b1; Address = CTRL_ADDR; DataIn = 16'h0000;
        #1;
        checks++;
        if (MemWe !== 1'b0) begin errors++; $display("FAIL idle ctrl we: got %b expected 0", MemWe); end
        bb = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge CLK);
            Write = 1'b0;
            if (Busy !== 1'b0) bb++;
        end
        checks++;
        if (bb !== 0) begin errors++; $display("FAIL idle zero start: busy cycles %0d expected 0", bb); end
        @(negedge CLK);
        Write = 1'b1; Address = 9'h105; DataIn = d;
        #1;
        checks++;
        if (MemWe !== 1'b1 || MemAddr !== 9'h105 || MemWData !== d) begin
            errors++; $display("FAIL idle pass write: we=%b addr=%h data=%h expected 1 105 %h", MemWe, MemAddr, MemWData, d);
        end
        @(negedge CLK);
        Write = 1'b0;
        #1;
        checks++;
        if (MemWe !== 1'b0) begin errors++; $display("FAIL idle we follow: got %b expected 0", MemWe); end
        @(negedge CLK);
        checks++;
        if (MemRData !== d) begin errors++; $display("FAIL idle readback: got %h expected %h", MemRData, d); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_signed();
        test_truncate();
        test_random();
        test_busy_ignore();
        test_abort();
        test_idle_passthrough();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
